// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store size encodings, the memory-stage state type and the bus byte-enable width.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave); request held until ack.
interface mem_stage_if;
   import riscv_pkg::*;

   logic            dmem_req;
   logic            dmem_we;
   logic [31:0]     dmem_addr;
   logic [31:0]     dmem_wdata;
   logic [BE_W-1:0] dmem_be;
   logic [31:0]     dmem_rdata;
   logic            dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data extraction: picks the byte/half at the lane and sign- or zero-extends it; purely combinational.
module load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (lane_i)
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         2'd3:    byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'h0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'h0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory stage: 1-cycle pass-through for non-memory/misaligned ops, >=2 cycles for bus ops; stall_o holds EX while busy.
// Optional MEM_TIMEOUT_EN: abandon a bus transaction after TIMEOUT_CYCLES BUSY cycles and flag bus_err_o.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic [31:0] alu_i,
   input  logic [31:0] store_data_i,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] pc_4_i,
   input  logic [2:0]  wb_sel1_i,
   input  logic [2:0]  wb_sel2_i,
   input  logic [2:0]  pc_sel_i,
   output logic        stall_o,
   mem_stage_if.master dmem,
   output logic        wb_valid_o,
   output logic [31:0] alu_o,
   output logic [31:0] mem_o,
   output logic [31:0] pc_4_o,
   output logic [2:0]  wb_sel1_o,
   output logic [2:0]  wb_sel2_o,
   output logic [2:0]  pc_sel_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   mem_state_e      state_q, state_d;
   logic [31:0]     req_addr_q, req_addr_d;
   logic [2:0]      req_f3_q, req_f3_d;
   logic [31:0]     req_wdata_q, req_wdata_d;
   logic [BE_W-1:0] req_be_q, req_be_d;
   logic            req_we_q, req_we_d;
   logic            wb_valid_q, wb_valid_d;
   logic [31:0]     alu_q, alu_d, mem_q, mem_d, pc_4_q, pc_4_d;
   logic [2:0]      wb_sel1_q, wb_sel1_d, wb_sel2_q, wb_sel2_d, pc_sel_q, pc_sel_d;
   logic            misalign_q, misalign_d;

   logic            mem_op, misal, capture, stall;
   logic [31:0]     st_wdata, load_data;
   logic [BE_W-1:0] st_be;

   assign mem_op = mem_rd_i | mem_wr_i;
   assign misal  = ((funct3_i[1:0] == 2'b01) && alu_i[0]) ||
                   ((funct3_i == F3_W) && (alu_i[1:0] != 2'b00));

   always_comb begin
      st_wdata = store_data_i;
      st_be    = '1;
      case (funct3_i[1:0])
         2'b00: begin
            st_wdata = {4{store_data_i[7:0]}};
            st_be    = BE_W'(4'b0001) << alu_i[1:0];
         end
         2'b01: begin
            st_wdata = {2{store_data_i[15:0]}};
            st_be    = BE_W'(4'b0011) << alu_i[1:0];
         end
         default: ;
      endcase
   end

   load_align u_load_align (
      .rdata_i  (dmem.dmem_rdata),
      .lane_i   (req_addr_q[1:0]),
      .funct3_i (req_f3_q),
      .data_o   (load_data)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   logic             bus_err_q, bus_err_d;

   // Counter sits at zero while idle, so it is already clear on BUSY entry.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (!dmem.dmem_ack) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err_o = bus_err_q;
`else
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      req_f3_d    = req_f3_q;
      req_wdata_d = req_wdata_q;
      req_be_d    = req_be_q;
      req_we_d    = req_we_q;
      wb_valid_d  = 1'b0;
      alu_d       = alu_q;
      mem_d       = mem_q;
      pc_4_d      = pc_4_q;
      wb_sel1_d   = wb_sel1_q;
      wb_sel2_d   = wb_sel2_q;
      pc_sel_d    = pc_sel_q;
      misalign_d  = misalign_q;
`ifdef MEM_TIMEOUT_EN
      bus_err_d   = bus_err_q;
`endif
      stall       = 1'b0;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid_i) begin
               if (mem_op && !misal) begin
                  stall       = 1'b1;
                  state_d     = BUSY;
                  req_addr_d  = alu_i;
                  req_f3_d    = funct3_i;
                  req_wdata_d = st_wdata;
                  req_be_d    = st_be;
                  req_we_d    = mem_wr_i & ~mem_rd_i;
               end else begin
                  capture    = 1'b1;
                  mem_d      = '0;
                  misalign_d = mem_op;
`ifdef MEM_TIMEOUT_EN
                  bus_err_d  = 1'b0;
`endif
               end
            end
         end
         BUSY: begin
            if (dmem.dmem_ack) begin
               capture    = 1'b1;
               state_d    = IDLE;
               mem_d      = req_we_q ? 32'h0 : load_data;
               misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
               bus_err_d  = 1'b0;
            end else if (timeout) begin
               capture    = 1'b1;
               state_d    = IDLE;
               mem_d      = '0;
               misalign_d = 1'b0;
               bus_err_d  = 1'b1;
`endif
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // EX still holds its fields in the completing cycle, so they are taken from the inputs.
      if (capture) begin
         wb_valid_d = 1'b1;
         alu_d      = alu_i;
         pc_4_d     = pc_4_i;
         wb_sel1_d  = wb_sel1_i;
         wb_sel2_d  = wb_sel2_i;
         pc_sel_d   = pc_sel_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_addr_q  <= '0;
         req_f3_q    <= '0;
         req_wdata_q <= '0;
         req_be_q    <= '0;
         req_we_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         alu_q       <= '0;
         mem_q       <= '0;
         pc_4_q      <= '0;
         wb_sel1_q   <= '0;
         wb_sel2_q   <= '0;
         pc_sel_q    <= '0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         req_f3_q    <= req_f3_d;
         req_wdata_q <= req_wdata_d;
         req_be_q    <= req_be_d;
         req_we_q    <= req_we_d;
         wb_valid_q  <= wb_valid_d;
         alu_q       <= alu_d;
         mem_q       <= mem_d;
         pc_4_q      <= pc_4_d;
         wb_sel1_q   <= wb_sel1_d;
         wb_sel2_q   <= wb_sel2_d;
         pc_sel_q    <= pc_sel_d;
         misalign_q  <= misalign_d;
      end
   end

   // Gating with reset keeps stall low while reset is held even if EX presents a memory op.
   assign stall_o         = stall & rst;
   assign dmem.dmem_req   = (state_q == BUSY);
   assign dmem.dmem_we    = req_we_q;
   assign dmem.dmem_addr  = {req_addr_q[31:2], 2'b00};
   assign dmem.dmem_wdata = req_wdata_q;
   assign dmem.dmem_be    = req_be_q;

   assign wb_valid_o = wb_valid_q;
   assign alu_o      = alu_q;
   assign mem_o      = mem_q;
   assign pc_4_o     = pc_4_q;
   assign wb_sel1_o  = wb_sel1_q;
   assign wb_sel2_o  = wb_sel2_q;
   assign pc_sel_o   = pc_sel_q;
   assign misalign_o = misalign_q;

endmodule
